// File: rtl/alu_bist.sv
// Built-in self-test engine for the 8-bit ALU.
// Drives LFSR operands for each opcode and checks results against a golden model.
module alu_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [7:0] AluInputA,
    output logic [7:0] AluInputB,
    output logic       AluSC_in,
    output logic [2:0] AluOP,
    input  logic [7:0] AluOut,
    input  logic       AluZero,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] ErrCount,
    output logic [2:0] FirstFailOp,
    output logic [7:0] FirstFailA,
    output logic [7:0] FirstFailB
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED =
        (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] vcnt;
    logic [7:0]  expect_out;
    logic        expect_zero;
    logic        mismatch;
    logic        last_vec;
    logic [2:0]  op_nxt;
    logic        start_ok;

    // Galois form of x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]};
        if (lfsr[0])
            lfsr_nxt = lfsr_nxt ^ 16'hB400;
    end

    always_comb begin
        expect_out = 8'h00;
        unique case (AluOP)
            3'b000: expect_out = AluInputA + AluInputB;
            3'b001: expect_out = {AluInputA[6:0], AluSC_in};
            3'b010: expect_out = {1'b0, AluInputA[7:1]};
            3'b011: expect_out = AluInputA ^ AluInputB;
            3'b100: expect_out = AluInputA & AluInputB;
            3'b101: expect_out = AluInputA - AluInputB;
            3'b110: expect_out = 8'h00;
            3'b111: expect_out = {7'b0, ^AluInputA};
        endcase
    end

    assign expect_zero = (expect_out == 8'h00);
    assign mismatch    = (AluOut != expect_out) || (AluZero != expect_zero);
    assign last_vec    = (vcnt == LAST);
    assign op_nxt      = (AluOP == 3'b101) ? 3'b111 : AluOP + 3'd1;
    assign start_ok    = Start && (state == S_IDLE || state == S_DONE);

    assign Busy = (state == S_DRIVE) || (state == S_CHECK);
    assign Done = (state == S_DONE);
    assign Pass = Done && (ErrCount == 8'h00);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            vcnt        <= 16'h0000;
            AluInputA   <= 8'h00;
            AluInputB   <= 8'h00;
            AluSC_in    <= 1'b0;
            AluOP       <= 3'b000;
            ErrCount    <= 8'h00;
            FirstFailOp <= 3'b000;
            FirstFailA  <= 8'h00;
            FirstFailB  <= 8'h00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state       <= S_DRIVE;
                        lfsr        <= SEED;
                        vcnt        <= 16'h0000;
                        AluInputA   <= SEED[15:8];
                        AluInputB   <= SEED[7:0];
                        AluSC_in    <= SEED[15] ^ SEED[0];
                        AluOP       <= 3'b000;
                        ErrCount    <= 8'h00;
                        FirstFailOp <= 3'b000;
                        FirstFailA  <= 8'h00;
                        FirstFailB  <= 8'h00;
                    end
                end
                S_DRIVE: state <= S_CHECK;
                S_CHECK: begin
                    lfsr <= lfsr_nxt;
                    if (mismatch) begin
                        if (ErrCount != 8'hFF)
                            ErrCount <= ErrCount + 8'd1;
                        if (ErrCount == 8'h00) begin
                            FirstFailOp <= AluOP;
                            FirstFailA  <= AluInputA;
                            FirstFailB  <= AluInputB;
                        end
                    end
                    // Outputs hold the final vector once the run ends.
                    if (last_vec && AluOP == 3'b111) begin
                        state <= S_DONE;
                        vcnt  <= 16'h0000;
                    end else begin
                        state     <= S_DRIVE;
                        AluInputA <= lfsr_nxt[15:8];
                        AluInputB <= lfsr_nxt[7:0];
                        AluSC_in  <= lfsr_nxt[15] ^ lfsr_nxt[0];
                        if (last_vec) begin
                            vcnt  <= 16'h0000;
                            AluOP <= op_nxt;
                        end else begin
                            vcnt <= vcnt + 16'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Directed testbench for alu_bist.
// Two instances: NUM_VECTORS=4 with a switchable ALU, NUM_VECTORS=64 inverting.
module tb_alu_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4;
    logic       start64;
    int         mode4;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] a4, b4, out4, err4, ffa4, ffb4;
    logic [2:0] op4, ffop4;
    logic       sc4, zero4, busy4, done4, pass4;

    logic [7:0] a64, b64, out64, err64, ffa64, ffb64;
    logic [2:0] op64, ffop64;
    logic       sc64, zero64, busy64, done64, pass64;

    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

    always #5 clk = ~clk;

    alu_bist #(.NUM_VECTORS(4)) dut4 (
        .Clk(clk), .Reset(rst), .Start(start4),
        .AluInputA(a4), .AluInputB(b4), .AluSC_in(sc4), .AluOP(op4),
        .AluOut(out4), .AluZero(zero4),
        .Busy(busy4), .Done(done4), .Pass(pass4), .ErrCount(err4),
        .FirstFailOp(ffop4), .FirstFailA(ffa4), .FirstFailB(ffb4)
    );

    alu_bist #(.NUM_VECTORS(64)) dut64 (
        .Clk(clk), .Reset(rst), .Start(start64),
        .AluInputA(a64), .AluInputB(b64), .AluSC_in(sc64), .AluOP(op64),
        .AluOut(out64), .AluZero(zero64),
        .Busy(busy64), .Done(done64), .Pass(pass64), .ErrCount(err64),
        .FirstFailOp(ffop64), .FirstFailA(ffa64), .FirstFailB(ffb64)
    );

    function automatic logic [7:0] gold(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic       sc);
        case (op)
            3'd0:    return a + b;
            3'd1:    return {a[6:0], sc};
            3'd2:    return {1'b0, a[7:1]};
            3'd3:    return a ^ b;
            3'd4:    return a & b;
            3'd5:    return a - b;
            3'd7:    return {7'b0, ^a};
            default: return 8'h00;
        endcase
    endfunction

    // Feedback bit re-enters at bit 15 and is xored into bits 13, 12, 10.
    function automatic logic [15:0] step(input logic [15:0] l);
        logic [15:0] n;
        logic        fb;
        fb    = l[0];
        n     = {fb, l[15:1]};
        n[13] = n[13] ^ fb;
        n[12] = n[12] ^ fb;
        n[10] = n[10] ^ fb;
        return n;
    endfunction

    always_comb begin
        out4 = gold(op4, a4, b4, sc4);
        if (mode4 == 1 && op4 == 3'd0)
            out4 = a4 + b4 + 8'd1;
        else if (mode4 == 2)
            out4 = ~out4;
        zero4 = (out4 == 8'h00);
    end

    always_comb begin
        out64  = ~gold(op64, a64, b64, sc64);
        zero64 = (out64 == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; starts dut4 and follows it to the end of the run.
    task automatic run4(input int poke, output int busy,
                        output logic [15:0] last);
        logic [15:0] l;
        int          v;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        busy   = 0;
        l      = 16'hACE1;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1)
                @(negedge clk);
            start4 = (c == poke);
            if (c == 1) begin
                chk("start_clr_done", done4, 0);
                chk("start_clr_err", err4, 0);
                chk("start_clr_ff", {ffop4, ffa4, ffb4}, 0);
                chk("first_vec", {a4, b4}, 16'hACE1);
            end
            if (c == 3)
                chk("second_vec", {a4, b4}, 16'hE270);
            if (!busy4)
                break;
            busy++;
            v = (c - 1) / 2;
            if (c > 1 && c % 2 == 1)
                l = step(l);
            if (v < 28) begin
                chk("op_seq", op4, ops[v / 4]);
                chk("operands", {a4, b4, sc4}, {l, l[15] ^ l[0]});
            end
        end
        start4 = 1'b0;
        last   = l;
    endtask

    initial begin
        int          busy;
        logic [15:0] last;
        rst     = 1'b0;
        start4  = 1'b0;
        start64 = 1'b0;
        mode4   = 0;

        #2 rst = 1'b1;
        #1;
        chk("rst_outs", {busy4, done4, pass4, sc4, op4, a4, b4, err4}, 0);
        chk("rst_ff", {ffop4, ffa4, ffb4}, 0);
        chk("rst_outs64", {busy64, done64, pass64, err64}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run4(0, busy, last);
        chk("golden_busy", busy, 56);
        chk("golden_done", {done4, pass4}, 2'b11);
        chk("golden_err", err4, 0);
        chk("done_hold", {a4, b4}, last);

        run4(10, busy, last);
        chk("poke_busy", busy, 56);
        chk("poke_pass", pass4, 1);

        mode4 = 1;
        run4(0, busy, last);
        chk("fault_busy", busy, 56);
        chk("fault_err", err4, 4);
        chk("fault_done", {done4, pass4}, 2'b10);
        chk("fault_ffop", ffop4, 0);
        chk("fault_ffa", ffa4, 8'hAC);
        chk("fault_ffb", ffb4, 8'hE1);

        mode4 = 0;
        run4(0, busy, last);
        chk("restart_busy", busy, 56);
        chk("restart_pass", pass4, 1);

        mode4  = 2;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_err", err4, 9);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_outs", {busy4, done4, pass4, sc4, op4, a4, b4, err4}, 0);
        chk("midrun_rst_ff", {ffop4, ffa4, ffb4}, 0);
        @(negedge clk);
        rst   = 1'b0;
        mode4 = 0;
        @(negedge clk);
        run4(0, busy, last);
        chk("rerun_busy", busy, 56);
        chk("rerun_result", {done4, pass4, err4}, {2'b11, 8'h00});

        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        busy    = 0;
        for (int c = 1; c <= 2000; c++) begin
            if (c > 1)
                @(negedge clk);
            if (!busy64)
                break;
            busy++;
        end
        chk("sat_busy", busy, 896);
        chk("sat_err", err64, 255);
        chk("sat_done", {done64, pass64}, 2'b10);
        chk("sat_ff", {ffop64, ffa64, ffb64}, {3'd0, 8'hAC, 8'hE1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
